control_sequencer: RTL

Hardwired Mini SRC control unit that replaces manual bench stimulus of `datapath` control inputs.
- Runs a fetch/execute FSM from IR_Data and CON_out.
- Drives every bus-in/bus-out, memory, select-encode and ALU control line of `datapath` one step per clock.
- Sits beside `datapath` in the CPU top level.

---
 rtl/control_sequencer_pkg.sv | 81 ++++++++
 rtl/control_sequencer_step_decoder.sv | 134 +++++++++++++
 rtl/control_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit.
//   - opcode values (5-bit field IR[31:27])
//   - FSM state encoding (T0..T7 plus HALT)
//   - instruction groups and the control word produced for each step
package minisrc_pkg;

    localparam int OP_W = 5;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFLO = 5'b11000;
    localparam logic [4:0] OP_MFHI = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU code used for effective-address and branch-target arithmetic
    localparam logic [4:0] ALU_ADD = OP_ADD;

    localparam logic [3:0] ST_T0   = 4'd0;
    localparam logic [3:0] ST_T1   = 4'd1;
    localparam logic [3:0] ST_T2   = 4'd2;
    localparam logic [3:0] ST_T3   = 4'd3;
    localparam logic [3:0] ST_T4   = 4'd4;
    localparam logic [3:0] ST_T5   = 4'd5;
    localparam logic [3:0] ST_T6   = 4'd6;
    localparam logic [3:0] ST_T7   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    typedef enum logic [3:0] {
        G_RALU, G_IMM, G_MULDIV, G_UNARY, G_LD, G_LDI, G_ST, G_BR,
        G_JR, G_JAL, G_IN, G_OUT, G_MFHI, G_MFLO, G_NOP, G_HALT
    } op_group_e;

    typedef struct packed {
        logic       pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in;
        logic       outport_in, inc_pc;
        logic       pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out;
        logic       inport_out, c_out;
        logic       read, write;
        logic       gra, grb, grc, rin, rout, ba_out, con_in;
        logic [4:0] alu;
        logic       mem_step;   // step is stretched by the memory-wait counter
        logic       last_step;  // final execute step of the instruction
        logic       to_halt;    // leave for HALT unconditionally
    } ctrl_word_t;

    function automatic op_group_e op_group(input logic [4:0] op);
        op_group_e g;
        g = G_NOP;
        if (op == OP_LD)                          g = G_LD;
        else if (op == OP_LDI)                    g = G_LDI;
        else if (op == OP_ST)                     g = G_ST;
        else if (op >= OP_ADD && op <= OP_SHL)    g = G_RALU;
        else if (op >= OP_ADDI && op <= OP_ORI)   g = G_IMM;
        else if (op == OP_DIV || op == OP_MUL)    g = G_MULDIV;
        else if (op == OP_NEG || op == OP_NOT)    g = G_UNARY;
        else if (op == OP_BR)                     g = G_BR;
        else if (op == OP_JAL)                    g = G_JAL;
        else if (op == OP_JR)                     g = G_JR;
        else if (op == OP_IN)                     g = G_IN;
        else if (op == OP_OUT)                    g = G_OUT;
        else if (op == OP_MFLO)                   g = G_MFLO;
        else if (op == OP_MFHI)                   g = G_MFHI;
        else if (op == OP_HALT)                   g = G_HALT;
        return g;
    endfunction

endpackage

// File: rtl/control_sequencer_step_decoder.sv
// Combinational step decoder: (state, opcode, CON_out) -> control word.
//   state_i  : current FSM step
//   opcode_i : IR[31:27]
//   con_i    : branch condition flip-flop output
//   cw_o     : strobes, ALU code and sequencing hints for the parent FSM
module step_decoder
    import minisrc_pkg::*;
#(
    parameter int OPW = OP_W
) (
    input  logic [3:0]     state_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           con_i,
    output ctrl_word_t     cw_o
);

    op_group_e grp;

    always_comb begin
        cw_o = '0;
        grp  = op_group(5'(opcode_i));
        case (state_i)
            ST_T0: begin cw_o.pc_out = 1'b1; cw_o.mar_in = 1'b1; cw_o.inc_pc = 1'b1; end
            ST_T1: begin cw_o.read = 1'b1; cw_o.mdr_in = 1'b1; cw_o.mem_step = 1'b1; end
            ST_T2: begin cw_o.mdr_out = 1'b1; cw_o.ir_in = 1'b1; end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                // ALU code is held for the whole execute phase of the instruction
                case (grp)
                    G_RALU, G_IMM, G_MULDIV, G_UNARY: cw_o.alu = 5'(opcode_i);
                    G_LD, G_LDI, G_ST, G_BR:          cw_o.alu = ALU_ADD;
                    default:                          cw_o.alu = 5'd0;
                endcase
                case (grp)
                    G_RALU, G_IMM: begin
                        case (state_i)
                            ST_T3: begin cw_o.grb = 1'b1; cw_o.rout = 1'b1; cw_o.y_in = 1'b1; end
                            ST_T4: begin
                                if (grp == G_IMM) cw_o.c_out = 1'b1;
                                else begin cw_o.grc = 1'b1; cw_o.rout = 1'b1; end
                                cw_o.z_in = 1'b1;
                            end
                            ST_T5: begin
                                cw_o.zlow_out = 1'b1; cw_o.gra = 1'b1; cw_o.rin = 1'b1;
                                cw_o.last_step = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    G_UNARY: begin
                        if (state_i == ST_T3) begin
                            cw_o.grb = 1'b1; cw_o.rout = 1'b1; cw_o.z_in = 1'b1;
                        end else begin
                            cw_o.zlow_out = 1'b1; cw_o.gra = 1'b1; cw_o.rin = 1'b1;
                            cw_o.last_step = 1'b1;
                        end
                    end
                    G_MULDIV: begin
                        case (state_i)
                            ST_T3: begin cw_o.gra = 1'b1; cw_o.rout = 1'b1; cw_o.y_in = 1'b1; end
                            ST_T4: begin cw_o.grb = 1'b1; cw_o.rout = 1'b1; cw_o.z_in = 1'b1; end
                            ST_T5: begin cw_o.zlow_out = 1'b1; cw_o.lo_in = 1'b1; end
                            ST_T6: begin
                                cw_o.zhigh_out = 1'b1; cw_o.hi_in = 1'b1; cw_o.last_step = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    G_LD, G_LDI, G_ST: begin
                        case (state_i)
                            ST_T3: begin cw_o.grb = 1'b1; cw_o.ba_out = 1'b1; cw_o.y_in = 1'b1; end
                            ST_T4: begin cw_o.c_out = 1'b1; cw_o.z_in = 1'b1; end
                            ST_T5: begin
                                cw_o.zlow_out = 1'b1;
                                if (grp == G_LDI) begin
                                    cw_o.gra = 1'b1; cw_o.rin = 1'b1; cw_o.last_step = 1'b1;
                                end else begin
                                    cw_o.mar_in = 1'b1;
                                end
                            end
                            ST_T6: begin
                                cw_o.mdr_in = 1'b1;
                                if (grp == G_LD) begin
                                    cw_o.read = 1'b1; cw_o.mem_step = 1'b1;
                                end else begin
                                    cw_o.gra = 1'b1; cw_o.rout = 1'b1;
                                end
                            end
                            ST_T7: begin
                                cw_o.last_step = 1'b1;
                                if (grp == G_LD) begin
                                    cw_o.mdr_out = 1'b1; cw_o.gra = 1'b1; cw_o.rin = 1'b1;
                                end else begin
                                    cw_o.write = 1'b1; cw_o.mem_step = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    G_BR: begin
                        case (state_i)
                            ST_T3: begin cw_o.gra = 1'b1; cw_o.rout = 1'b1; cw_o.con_in = 1'b1; end
                            ST_T4: begin cw_o.pc_out = 1'b1; cw_o.y_in = 1'b1; end
                            ST_T5: begin cw_o.c_out = 1'b1; cw_o.z_in = 1'b1; end
                            ST_T6: begin
                                // branch target only committed when the condition latched in T3 holds
                                cw_o.zlow_out  = con_i;
                                cw_o.pc_in     = con_i;
                                cw_o.last_step = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    G_JAL: begin
                        if (state_i == ST_T3) begin
                            cw_o.pc_out = 1'b1; cw_o.grb = 1'b1; cw_o.rin = 1'b1;
                        end else begin
                            cw_o.gra = 1'b1; cw_o.rout = 1'b1; cw_o.pc_in = 1'b1;
                            cw_o.last_step = 1'b1;
                        end
                    end
                    G_JR:   begin cw_o.gra = 1'b1; cw_o.rout = 1'b1; cw_o.pc_in = 1'b1; cw_o.last_step = 1'b1; end
                    G_IN:   begin cw_o.inport_out = 1'b1; cw_o.gra = 1'b1; cw_o.rin = 1'b1; cw_o.last_step = 1'b1; end
                    G_OUT:  begin cw_o.gra = 1'b1; cw_o.rout = 1'b1; cw_o.outport_in = 1'b1; cw_o.last_step = 1'b1; end
                    G_MFHI: begin cw_o.hi_out = 1'b1; cw_o.gra = 1'b1; cw_o.rin = 1'b1; cw_o.last_step = 1'b1; end
                    G_MFLO: begin cw_o.lo_out = 1'b1; cw_o.gra = 1'b1; cw_o.rin = 1'b1; cw_o.last_step = 1'b1; end
                    G_HALT: begin cw_o.last_step = 1'b1; cw_o.to_halt = 1'b1; end
                    default: cw_o.last_step = 1'b1;
                endcase
            end
            default: ;  // HALT: no strobes
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC hardwired control unit: fetch/execute FSM driving the datapath.
//   clk, clr         : clock and synchronous active-high reset
//   IR_Data, CON_out : instruction register and branch condition from datapath
//   stop             : halt request honoured at the end of the current instruction
//   *_in/*_out/...   : datapath control strobes, one step per clock
//   alu_instruction_bits : ALU operation code
//   run              : high except in HALT
module control_sequencer
    import minisrc_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int          OPW     = OP_W
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    input  logic        stop,
    output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
    output logic        OutPort_in, IncPC,
    output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
    output logic        InPort_out, C_out,
    output logic        Read, Write,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, CON_in,
    output logic [4:0]  alu_instruction_bits,
    output logic        run
);

    localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

    logic [3:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       rst_q;          // high for the cycle following any clr-high edge
    ctrl_word_t cw, cw_out;
    logic       unused_ir;

    assign unused_ir = ^IR_Data[31-OPW:0];

    step_decoder #(.OPW(OPW)) u_step_decoder (
        .state_i  (state_q),
        .opcode_i (IR_Data[31 -: OPW]),
        .con_i    (CON_out),
        .cw_o     (cw)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst_q) begin
            // hold T0 silent for one cycle so an aborted instruction leaves no strobes
            state_d = ST_T0;
            cnt_d   = 2'd0;
        end else if (state_q == ST_HALT) begin
            state_d = ST_HALT;
        end else if (cw.mem_step && cnt_q != LAT_M1) begin
            cnt_d = cnt_q + 2'd1;
        end else begin
            cnt_d = 2'd0;
            if (cw.to_halt)        state_d = ST_HALT;
            else if (cw.last_step) state_d = stop ? ST_HALT : ST_T0;
            else                   state_d = state_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_T0;
            cnt_q   <= 2'd0;
            rst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= 1'b0;
        end
    end

    assign cw_out = rst_q ? '0 : cw;

    assign PC_in      = cw_out.pc_in;
    assign IR_in      = cw_out.ir_in;
    assign Y_in       = cw_out.y_in;
    assign Z_in       = cw_out.z_in;
    assign HI_in      = cw_out.hi_in;
    assign LO_in      = cw_out.lo_in;
    assign MAR_in     = cw_out.mar_in;
    assign MDR_in     = cw_out.mdr_in;
    assign OutPort_in = cw_out.outport_in;
    assign IncPC      = cw_out.inc_pc;
    assign PC_out     = cw_out.pc_out;
    assign Zhigh_out  = cw_out.zhigh_out;
    assign Zlow_out   = cw_out.zlow_out;
    assign HI_out     = cw_out.hi_out;
    assign LO_out     = cw_out.lo_out;
    assign MDR_out    = cw_out.mdr_out;
    assign InPort_out = cw_out.inport_out;
    assign C_out      = cw_out.c_out;
    assign Read       = cw_out.read;
    assign Write      = cw_out.write;
    assign Gra        = cw_out.gra;
    assign Grb        = cw_out.grb;
    assign Grc        = cw_out.grc;
    assign Rin        = cw_out.rin;
    assign Rout       = cw_out.rout;
    assign BAout      = cw_out.ba_out;
    assign CON_in     = cw_out.con_in;
    assign alu_instruction_bits = cw_out.alu;
    assign run        = rst_q | (state_q != ST_HALT);

endmodule
